perceptron_update: RTL and testbench

PERCEPTRON_UPDATE -- requirements
Module: perceptron_update

---
 rtl/perceptron_update.sv | 141 ++++++++++++++
 tb/tb_perceptron_update.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_update.sv
// perceptron_update: sequential weight update for a single perceptron.
//
// One pass updates every weight in turn, one per clock:
//   w[i] += err * (in[i] >>> SHIFT)      (the bias uses BIAS_IN instead of in[i])
// Each sum is saturated to the signed W-bit range. When err is 0 the pass
// goes straight to DONE and leaves the weights alone.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   start                 request a pass (sampled in IDLE only)
//   in_vec                N_IN x W inputs, element i at [i*W +: W]
//   out_bit, target       neuron output and desired output; err = target - out_bit
//   wr_en/wr_addr/wr_data direct weight write, honoured in IDLE only
//   weights               (N_IN+1) x W weights, bias at index N_IN
//   busy, done            busy = not IDLE; done = one-cycle DONE state
//   update_cnt            number of passes with nonzero err (wraps)

module perceptron_sat_acc #(
  parameter int W = 32
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] opnd_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o
);
  logic [W:0] a, b, s;

  always_comb begin
    a = {acc_i[W-1], acc_i};
    b = {opnd_i[W-1], opnd_i};
    s = sub_i ? (a - b) : (a + b);
    // The top two bits disagree only when the W-bit result has overflowed.
    if (s[W] != s[W-1]) sum_o = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else                sum_o = s[W-1:0];
  end
endmodule

module perceptron_update #(
  parameter int             N_IN    = 32,
  parameter int             W       = 32,
  parameter int             SHIFT   = 4,
  parameter logic [W-1:0]   INIT_W  = 4,
  parameter logic [W-1:0]   BIAS_IN = 32'h3FFFFFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_IN*W-1:0]     in_vec,
  input  logic                  out_bit,
  input  logic                  target,
  input  logic                  wr_en,
  input  logic [5:0]            wr_addr,
  input  logic [W-1:0]          wr_data,
  output logic [(N_IN+1)*W-1:0] weights,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           update_cnt
);
  localparam int IW = $clog2(N_IN + 1);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     err_neg_q, err_neg_d;   // err is -1 (else +1) while in UPDATE
  logic [N_IN*W-1:0]        in_q, in_d;
  logic [N_IN:0][W-1:0]     w_q, w_d;
  logic [15:0]              cnt_q, cnt_d;

  // Operand table: latched inputs followed by the constant bias input.
  logic [N_IN:0][W-1:0]     opnd_vec;
  logic [W-1:0]             opnd_raw, opnd, sum;

  assign opnd_vec = {BIAS_IN, in_q};
  assign opnd_raw = opnd_vec[idx_q];
  assign opnd     = W'($signed(opnd_raw) >>> SHIFT);

  perceptron_sat_acc #(.W(W)) u_acc (
    .acc_i  (w_q[idx_q]),
    .opnd_i (opnd),
    .sub_i  (err_neg_q),
    .sum_o  (sum)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_neg_d = err_neg_q;
    in_d      = in_q;
    w_d       = w_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // start wins over a simultaneous write.
          in_d      = in_vec;
          err_neg_d = out_bit & ~target;
          idx_d     = '0;
          if (out_bit != target) begin
            state_d = S_UPDATE;
            cnt_d   = cnt_q + 16'd1;
          end else begin
            state_d = S_DONE;
          end
        end else if (wr_en && (int'(wr_addr) <= N_IN)) begin
          w_d[wr_addr] = wr_data;
        end
      end
      S_UPDATE: begin
        w_d[idx_q] = sum;
        idx_d      = idx_q + IW'(1);
        if (idx_q == IW'(N_IN)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      err_neg_q <= 1'b0;
      in_q      <= '0;
      w_q       <= {(N_IN+1){INIT_W}};
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_neg_q <= err_neg_d;
      in_q      <= in_d;
      w_q       <= w_d;
      cnt_q     <= cnt_d;
    end
  end

  assign weights    = w_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign update_cnt = cnt_q;
endmodule

// File: tb/tb_perceptron_update.sv
module tb_perceptron_update;
  localparam int N  = 32;
  localparam int WW = 32;
  localparam logic [31:0] BIAS = 32'h3FFFFFFF;

  logic                 clk = 0, rst_n = 0;
  logic                 start = 0, out_bit = 0, target = 0, wr_en = 0;
  logic [N*WW-1:0]      in_vec = '0;
  logic [5:0]           wr_addr = '0;
  logic [WW-1:0]        wr_data = '0;
  logic [(N+1)*WW-1:0]  weights;
  logic                 busy, done;
  logic [15:0]          update_cnt;

  perceptron_update dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_vec(in_vec), .out_bit(out_bit),
    .target(target), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .weights(weights), .busy(busy), .done(done), .update_cnt(update_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model state.
  logic signed [31:0] mw [0:N];
  logic [15:0]        mcnt;

  typedef struct {
    logic [(N+1)*WW-1:0] w;
    logic [15:0]         cnt;
    int                  lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          do_rst;
    logic [31:0] a0, a1, rest;
    bit          ob, tg;
    int          tag;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic chk_w(input string nm, input logic [(N+1)*WW-1:0] req);
    checks++;
    if (weights !== req) begin
      failures++;
      for (int i = 0; i <= N; i++)
        if (weights[i*WW +: WW] !== req[i*WW +: WW]) begin
          $display("FAIL %s: w[%0d] got %h expected %h", nm, i, weights[i*WW +: WW], req[i*WW +: WW]);
          break;
        end
    end
  endtask

  function automatic logic [(N+1)*WW-1:0] mpack();
    logic [(N+1)*WW-1:0] r;
    for (int i = 0; i <= N; i++) r[i*WW +: WW] = mw[i];
    return r;
  endfunction

  function automatic logic [N*WW-1:0] mkvec(input logic [31:0] a0, a1, rest);
    logic [N*WW-1:0] v;
    for (int i = 0; i < N; i++) v[i*WW +: WW] = rest;
    v[31:0]  = a0;
    v[63:32] = a1;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= N; i++) mw[i] = 32'sd4;
    mcnt = 0;
  endtask

  task automatic model_pass(input logic [N*WW-1:0] v, input int err);
    for (int i = 0; i <= N; i++) begin
      logic [31:0] x;
      longint op, s;
      x  = (i < N) ? v[i*WW +: WW] : BIAS;
      op = longint'($signed(x)) >>> 4;
      s  = longint'(mw[i]) + longint'(err) * op;
      if (s > 64'sd2147483647)       s = 64'sd2147483647;
      else if (s < -64'sd2147483648) s = -64'sd2147483648;
      mw[i] = s[31:0];
    end
    if (err != 0) mcnt = mcnt + 16'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    start = 0; wr_en = 0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    @(negedge clk);
    wr_en = 1; wr_addr = 6'(addr); wr_data = data;
    if (addr <= N) mw[addr] = data;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic run_pass(input logic [N*WW-1:0] v, input bit ob, input bit tg,
                          input bit wr_also, input int addr, input logic [31:0] data);
    int   err, lat;
    bit   got;
    exp_t e;
    err = int'(tg) - int'(ob);
    @(negedge clk);
    in_vec = v; out_bit = ob; target = tg; start = 1;
    wr_en = wr_also; wr_addr = 6'(addr); wr_data = data;
    model_pass(v, err);
    e.w = mpack(); e.cnt = mcnt; e.lat = (err != 0) ? N + 2 : 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 0; wr_en = 0;
    in_vec = ~v; out_bit = ~ob; target = ~tg;   // must not affect the pass
    lat = 0; got = 0;
    while (lat < 200 && !got) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("busy_after_accept", 64'(busy), 64'd1);
      if (done) got = 1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles");
    end else begin
      e = sb.pop_front();
      chk("done_latency", 64'(lat), 64'(e.lat));
      chk_w("weights", e.w);
      chk("update_cnt", 64'(update_cnt), 64'(e.cnt));
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("busy_cleared", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    vec_t tbl[5];
    tbl[0] = '{1'b0, 32'h00000100, 32'h00000100, 32'h00000100, 1'b1, 1'b1, 0};
    tbl[1] = '{1'b0, 32'h00000100, 32'h00000100, 32'h00000100, 1'b0, 1'b1, 39};
    tbl[2] = '{1'b1, 32'h80000000, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 40};
    tbl[3] = '{1'b0, 32'h12345678, 32'hFEDCBA98, 32'h00ABCDEF, 1'b0, 1'b1, 0};
    tbl[4] = '{1'b0, 32'hDEADBEEF, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 0};

    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk_w("reset_weights", mpack());
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_cnt", 64'(update_cnt), 64'd0);

    for (int k = 0; k < 5; k++) begin
      if (tbl[k].do_rst) do_reset();
      run_pass(mkvec(tbl[k].a0, tbl[k].a1, tbl[k].rest), tbl[k].ob, tbl[k].tg, 1'b0, 0, '0);
      if (tbl[k].tag == 39) begin
        chk("w0_plus", 64'(weights[31:0]), 64'd20);
        chk("bias_plus", 64'(weights[N*WW +: WW]), 64'h04000003);
      end else if (tbl[k].tag == 40) begin
        chk("w0_minus", 64'(weights[31:0]), 64'h08000004);
        chk("bias_minus", 64'(weights[N*WW +: WW]), 64'hFC000005);
      end
    end

    // Direct writes; out-of-range address ignored; write dropped alongside start.
    wr(3, 32'h11111111);
    wr(N, 32'h22222222);
    wr(40, 32'h33333333);
    @(negedge clk);
    chk_w("direct_writes", mpack());
    run_pass(mkvec(32'h1, 32'h2, 32'h3), 1'b1, 1'b1, 1'b1, 5, 32'h55555555);

    // Saturation at both ends.
    wr(0, 32'h7FFFFFF0);
    run_pass(mkvec(32'h7FFFFFFF, 32'h0, 32'h0), 1'b0, 1'b1, 1'b0, 0, '0);
    chk("sat_high", 64'(weights[31:0]), 64'h7FFFFFFF);
    wr(1, 32'h80000005);
    run_pass(mkvec(32'h0, 32'h7FFFFFFF, 32'h0), 1'b1, 1'b0, 1'b0, 0, '0);
    chk("sat_low", 64'(weights[63:32]), 64'h80000000);

    // Start/write while busy ignored, then reset mid-update.
    @(negedge clk);
    in_vec = mkvec(32'h100, 32'h100, 32'h100); out_bit = 0; target = 1; start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 5) begin
        start = 1; wr_en = 1; wr_addr = 6'd0; wr_data = 32'h5A5A5A5A;
        in_vec = ~in_vec; target = 0;
      end else begin
        start = 0; wr_en = 0;
      end
      if (c == 10) begin
        rst_n = 0;
        #1;
        model_reset();
        chk_w("reset_mid_update", mpack());
        chk("reset_mid_busy", 64'(busy), 64'd0);
        chk("reset_mid_cnt", 64'(update_cnt), 64'd0);
      end
    end
    @(negedge clk);
    rst_n = 1;
    run_pass(mkvec(32'h00000100, 32'h00000100, 32'h00000100), 1'b0, 1'b1, 1'b0, 0, '0);
    chk("post_reset_w0", 64'(weights[31:0]), 64'd20);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
